dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter NTHREADS, default 4, meaning the number of hardware-thread requesters (2..8).
REQ-002 The block SHALL have parameter SIZE, default 128, meaning the data memory depth in 32-bit words; the index is 7 bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 nReset  input  1  reset, asynchronous assert, active-low.
REQ-005 ReqValid  input  NTHREADS  per-thread request valid.
REQ-006 ReqWrite  input  NTHREADS  per-thread request type: 1 = store, 0 = load.
REQ-007 ReqIndex  input  NTHREADS*7  per-thread word index; thread t occupies bits [7t+6:7t].
REQ-008 ReqData  input  NTHREADS*32  per-thread store data; thread t occupies bits [32t+31:32t].
REQ-009 ReqGrant  output  NTHREADS  per-thread combinational grant; a request is consumed in a cycle where ReqValid and ReqGrant are both 1.
REQ-010 RespValid  output  1  load data valid.
REQ-011 RespThread  output  clog2(NTHREADS)  ID of the thread owning RespData.
REQ-012 RespData  output  32  load data.
REQ-013 RespReady  input  1  consumer accepts the response.
REQ-014 Busy  output  1  init sequence in progress.
REQ-015 WriteCache, CacheIndexWrite[6:0], WriteDataCache[31:0], ReadEnable, CacheIndexRead[6:0]  outputs  memory write/read port controls.
REQ-016 CacheData  input  32  memory read data; it is registered, appears 1 cycle after ReadEnable, and holds while ReadEnable is 0.

Function
REQ-017 The block SHALL contain two independent round-robin arbiters: a load arbiter over ReqValid&~ReqWrite and a store arbiter over ReqValid&ReqWrite; each grants at most one thread per cycle.
REQ-018 Each arbiter SHALL search from its pointer upward (mod NTHREADS) and, on a grant to thread g, SHALL set its pointer to (g+1) mod NTHREADS; the pointer SHALL be unchanged with no grant.
REQ-019 A granted store SHALL drive WriteCache=1, CacheIndexWrite and WriteDataCache from that thread in the same cycle.
REQ-020 A granted load SHALL drive ReadEnable=1 and CacheIndexRead in the same cycle; in the next cycle RespValid SHALL be 1 with RespThread=g.
REQ-021 Stall: while RespValid=1 and RespReady=0, the block SHALL grant no load, and RespValid, RespThread and RespData SHALL hold; stores remain grantable.
REQ-022 With RespValid=1 and RespReady=1, a new load MAY be granted in the same cycle (back-to-back throughput 1/cycle).
REQ-023 Forwarding: when a store and a load to the same index are granted in the same cycle, the response SHALL carry the new store data, not the stale CacheData.
REQ-024 RespData SHALL be 0 whenever RespValid=0.
REQ-025 FSM states: INIT (Busy=1, all grants 0) and RUN (Busy=0); INIT->RUN occurs after the last init write.

Reset
REQ-026 On nReset=0, the block SHALL immediately set RespValid=0, RespThread=0, RespData=0, ReqGrant=0, WriteCache=0, ReadEnable=0, both pointers to 0, and the init counter to 0.
REQ-027 Reset asserted mid-init or mid-stall SHALL discard all in-flight state; on release, the FSM SHALL enter INIT (macro defined) or RUN (macro undefined).

Configuration
REQ-028 With DMEM_INIT_CLEAR_EN defined, INIT SHALL write 0 to indices 0..SIZE-1, one per cycle (WriteCache=1), so Busy lasts exactly SIZE cycles after reset release.
REQ-029 Without DMEM_INIT_CLEAR_EN, INIT SHALL be absent, Busy SHALL be tied to 0, and the block SHALL be in RUN from reset release.

Verification
REQ-030 Init: macro defined, release reset -> Busy=1 for 128 cycles, writes 0 to indices 0..127, no grants; a load of index 5 afterwards -> RespData=0.
REQ-031 Round-robin: 4 threads each continuously loading -> grants in order 0,1,2,3,0 on consecutive cycles, with RespThread following one cycle later.
REQ-032 Forwarding: thread 1 stores 0xDEADBEEF to index 9 while thread 2 loads index 9 in the same cycle -> next cycle RespValid=1, RespThread=2, RespData=0xDEADBEEF.
REQ-033 Backpressure: RespReady=0 for 3 cycles with a pending response 0x1234 -> RespValid/RespData held at 0x1234 and no load grants; a concurrent store is still granted.
REQ-034 Reset mid-operation: assert nReset during a stalled response -> RespValid=0 and ReqGrant=0 at once; after release, the pointers grant thread 0 first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin load/store arbiter in front of a single-port-pair
// data memory (one write port, one registered read port), with same-cycle
// store-to-load forwarding and a stallable one-entry load response.
// Optional feature macro: DMEM_INIT_CLEAR_EN -- when defined, the memory is
// cleared to zero (one word per cycle) after every reset release and Busy is
// high for the duration.
module dmem_arbiter #(
  parameter int unsigned NTHREADS = 4,
  parameter int unsigned SIZE     = 128
) (
  input  logic                                 clk,
  input  logic                                 nReset,
  input  logic [NTHREADS-1:0]                  ReqValid,
  input  logic [NTHREADS-1:0]                  ReqWrite,
  input  logic [NTHREADS*$clog2(SIZE)-1:0]     ReqIndex,
  input  logic [NTHREADS*32-1:0]               ReqData,
  output logic [NTHREADS-1:0]                  ReqGrant,
  output logic                                 RespValid,
  output logic [$clog2(NTHREADS)-1:0]          RespThread,
  output logic [31:0]                          RespData,
  input  logic                                 RespReady,
  output logic                                 Busy,
  output logic                                 WriteCache,
  output logic [$clog2(SIZE)-1:0]              CacheIndexWrite,
  output logic [31:0]                          WriteDataCache,
  output logic                                 ReadEnable,
  output logic [$clog2(SIZE)-1:0]              CacheIndexRead,
  input  logic [31:0]                          CacheData
);

  localparam int unsigned TW = $clog2(NTHREADS);
  localparam int unsigned IW = $clog2(SIZE);
  localparam int unsigned DW = 32;

  logic [TW-1:0] ld_ptr, st_ptr;
  logic [TW-1:0] ld_sel, st_sel;
  logic          ld_found, st_found;
  int unsigned   ld_k, st_k;
  logic          ld_gnt, st_gnt;
  logic          run, stall;
  logic [IW-1:0] ld_idx, st_idx;
  logic [DW-1:0] st_data;
  logic          resp_valid;
  logic [TW-1:0] resp_thread;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          init_active;
  logic [IW-1:0] init_cnt;

`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t state;

  // Clear sequence: one zero write per cycle, then hand over to normal operation
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == IW'(SIZE - 1)) state <= ST_RUN;
    end
  end

  assign init_active = (state == ST_INIT);
  assign Busy        = init_active;
`else
  assign init_cnt    = '0;
  assign init_active = 1'b0;
  assign Busy        = 1'b0;
`endif

  assign run   = nReset & ~init_active;
  assign stall = resp_valid & ~RespReady;

  // Rotating-priority search from each pointer upward
  always_comb begin
    ld_found = 1'b0;
    ld_sel   = '0;
    st_found = 1'b0;
    st_sel   = '0;
    ld_k     = 0;
    st_k     = 0;
    for (int unsigned i = 0; i < NTHREADS; i++) begin
      ld_k = (32'(ld_ptr) + i) % NTHREADS;
      st_k = (32'(st_ptr) + i) % NTHREADS;
      if (!ld_found && ReqValid[TW'(ld_k)] && !ReqWrite[TW'(ld_k)]) begin
        ld_found = 1'b1;
        ld_sel   = TW'(ld_k);
      end
      if (!st_found && ReqValid[TW'(st_k)] && ReqWrite[TW'(st_k)]) begin
        st_found = 1'b1;
        st_sel   = TW'(st_k);
      end
    end
  end

  assign ld_gnt  = ld_found & run & ~stall;
  assign st_gnt  = st_found & run;
  assign ld_idx  = ReqIndex[32'(ld_sel)*IW +: IW];
  assign st_idx  = ReqIndex[32'(st_sel)*IW +: IW];
  assign st_data = ReqData[32'(st_sel)*DW +: DW];

  // One-hot grant vector merged from both arbiters
  always_comb begin
    ReqGrant = '0;
    if (ld_gnt) ReqGrant[ld_sel] = 1'b1;
    if (st_gnt) ReqGrant[st_sel] = 1'b1;
  end

  // Memory port drive: clear sequence owns the write port while active
  assign WriteCache      = nReset & (init_active | st_gnt);
  assign CacheIndexWrite = init_active ? init_cnt : st_idx;
  assign WriteDataCache  = init_active ? '0 : st_data;
  assign ReadEnable      = ld_gnt;
  assign CacheIndexRead  = ld_idx;

  // Pointer advance and response tracking; a hit on the same-cycle store is
  // captured here because the memory read returns the pre-write word
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      ld_ptr      <= '0;
      st_ptr      <= '0;
      resp_valid  <= 1'b0;
      resp_thread <= '0;
      fwd_hit     <= 1'b0;
      fwd_data    <= '0;
    end else begin
      if (ld_gnt) ld_ptr <= (32'(ld_sel) == NTHREADS - 1) ? '0 : ld_sel + 1'b1;
      if (st_gnt) st_ptr <= (32'(st_sel) == NTHREADS - 1) ? '0 : st_sel + 1'b1;
      if (ld_gnt) begin
        resp_valid  <= 1'b1;
        resp_thread <= ld_sel;
        fwd_hit     <= st_gnt && (st_idx == ld_idx);
        fwd_data    <= st_data;
      end else if (RespReady) begin
        resp_valid <= 1'b0;
        fwd_hit    <= 1'b0;
      end
    end
  end

  // Read data holds while stalled since no new read is issued
  assign RespValid  = resp_valid;
  assign RespThread = resp_thread;
  assign RespData   = resp_valid ? (fwd_hit ? fwd_data : CacheData) : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model of the memory,
// the two round-robin arbiters and the response slot.
module tb_dmem_arbiter;

  localparam int N    = 4;
  localparam int SIZE = 128;
`ifdef DMEM_INIT_CLEAR_EN
  localparam int INIT_CYCLES = SIZE;
  localparam logic [31:0] EXP_IDX5 = 32'h0;
`else
  localparam int INIT_CYCLES = 0;
  localparam logic [31:0] EXP_IDX5 = 32'h5A00_0005;
`endif

  logic           clk = 1'b0;
  logic           nReset = 1'b1;
  logic [N-1:0]   ReqValid = '0;
  logic [N-1:0]   ReqWrite = '0;
  logic [N*7-1:0] ReqIndex = '0;
  logic [N*32-1:0] ReqData = '0;
  logic [N-1:0]   ReqGrant;
  logic           RespValid;
  logic [1:0]     RespThread;
  logic [31:0]    RespData;
  logic           RespReady = 1'b1;
  logic           Busy;
  logic           WriteCache;
  logic [6:0]     CacheIndexWrite;
  logic [31:0]    WriteDataCache;
  logic           ReadEnable;
  logic [6:0]     CacheIndexRead;
  logic [31:0]    CacheData;

  always #5 clk = ~clk;

  dmem_arbiter #(.NTHREADS(N), .SIZE(SIZE)) dut (
    .clk(clk), .nReset(nReset),
    .ReqValid(ReqValid), .ReqWrite(ReqWrite), .ReqIndex(ReqIndex), .ReqData(ReqData),
    .ReqGrant(ReqGrant), .RespValid(RespValid), .RespThread(RespThread), .RespData(RespData),
    .RespReady(RespReady), .Busy(Busy),
    .WriteCache(WriteCache), .CacheIndexWrite(CacheIndexWrite), .WriteDataCache(WriteDataCache),
    .ReadEnable(ReadEnable), .CacheIndexRead(CacheIndexRead), .CacheData(CacheData)
  );

  // External memory: read-before-write, registered read data; preloaded once
  logic [31:0] sram [SIZE];
  logic        fill_done = 1'b0;
  always @(posedge clk) begin
    if (!nReset && !fill_done) begin
      for (int i = 0; i < SIZE; i++) sram[i] <= 32'h5A00_0000 + 32'(i);
      CacheData <= 32'h0;
      fill_done <= 1'b1;
    end else begin
      if (ReadEnable) CacheData <= sram[CacheIndexRead];
      if (WriteCache) sram[CacheIndexWrite] <= WriteDataCache;
    end
  end

  // Reference model state
  logic [31:0] mem_ref [SIZE];
  int          ld_ptr, st_ptr, busy_cnt;
  logic        pv;
  int          pt;
  logic [31:0] pd;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (ptr + i) % N;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N*7-1:0] idx_at(input int t, input int x);
    logic [N*7-1:0] r;
    r = '0;
    r[t*7 +: 7] = 7'(x);
    return r;
  endfunction

  function automatic logic [N*32-1:0] dat_at(input int t, input logic [31:0] x);
    logic [N*32-1:0] r;
    r = '0;
    r[t*32 +: 32] = x;
    return r;
  endfunction

  // One clock cycle: check registered outputs, apply inputs, check same-cycle
  // outputs, then advance the model; returns just before the next rising edge
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] w,
                      input logic [N*7-1:0] idx, input logic [N*32-1:0] dat,
                      input logic rdy);
    int gl, gs;
    logic [N-1:0] eg;
    logic [6:0] li, si;
    logic [31:0] sd;
    @(negedge clk);
    check("resp_valid", 32'(RespValid), 32'(pv));
    check("resp_data", RespData, pv ? pd : 32'h0);
    if (pv) check("resp_thread", 32'(RespThread), 32'(pt));
    ReqValid = v; ReqWrite = w; ReqIndex = idx; ReqData = dat; RespReady = rdy;
    #1;
    check("busy", 32'(Busy), 32'(busy_cnt > 0));
    gl = -1; gs = -1; eg = '0; li = '0; si = '0; sd = '0;
    if (busy_cnt > 0) begin
      check("init_grant", 32'(ReqGrant), 32'h0);
      check("init_we", 32'(WriteCache), 32'h1);
      check("init_idx", 32'(CacheIndexWrite), 32'(SIZE - busy_cnt));
      check("init_data", WriteDataCache, 32'h0);
      check("init_re", 32'(ReadEnable), 32'h0);
      mem_ref[SIZE - busy_cnt] = 32'h0;
      busy_cnt--;
    end else begin
      if (!(pv && !rdy)) gl = pick(v & ~w, ld_ptr);
      gs = pick(v & w, st_ptr);
      if (gl >= 0) eg = eg | (N'(1) << gl);
      if (gs >= 0) eg = eg | (N'(1) << gs);
      check("grant", 32'(ReqGrant), 32'(eg));
      check("write_en", 32'(WriteCache), 32'(gs >= 0));
      check("read_en", 32'(ReadEnable), 32'(gl >= 0));
      if (gs >= 0) begin
        si = idx[gs*7 +: 7];
        sd = dat[gs*32 +: 32];
        check("write_idx", 32'(CacheIndexWrite), 32'(si));
        check("write_data", WriteDataCache, sd);
        st_ptr = (gs + 1) % N;
      end
      if (gl >= 0) begin
        li = idx[gl*7 +: 7];
        check("read_idx", 32'(CacheIndexRead), 32'(li));
        pv = 1'b1;
        pt = gl;
        pd = (gs >= 0 && si == li) ? sd : mem_ref[li];
        ld_ptr = (gl + 1) % N;
      end else if (rdy) begin
        pv = 1'b0;
      end
      if (gs >= 0) mem_ref[si] = sd;
    end
  endtask

  // Asynchronous reset with immediate-effect checks, released after a rising edge
  task automatic apply_reset();
    @(negedge clk);
    ReqValid = '1; ReqWrite = '0; RespReady = 1'b0;
    nReset = 1'b0;
    #1;
    check("rst_resp_valid", 32'(RespValid), 32'h0);
    check("rst_resp_data", RespData, 32'h0);
    check("rst_resp_thread", 32'(RespThread), 32'h0);
    check("rst_grant", 32'(ReqGrant), 32'h0);
    check("rst_write_en", 32'(WriteCache), 32'h0);
    check("rst_read_en", 32'(ReadEnable), 32'h0);
    ld_ptr = 0; st_ptr = 0; pv = 1'b0; pt = 0; pd = '0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    nReset = 1'b1;
    busy_cnt = INIT_CYCLES;
  endtask

  initial begin
    for (int i = 0; i < SIZE; i++) mem_ref[i] = 32'h5A00_0000 + 32'(i);
    ld_ptr = 0; st_ptr = 0; busy_cnt = 0; pv = 1'b0; pt = 0; pd = '0;
    #2;
    apply_reset();

    // Clear sequence (if built in) with every thread requesting a load
    repeat (INIT_CYCLES) step('1, '0, '0, '0, 1'b1);

    // Round-robin over four continuous loaders
    for (int i = 0; i < 5; i++) begin
      step('1, '0, idx_at(0, 1) | idx_at(1, 2) | idx_at(2, 3) | idx_at(3, 4), '0, 1'b1);
      check("rr_grant", 32'(ReqGrant), 32'(N'(1) << (i % N)));
      if (i > 0) check("rr_resp_thread", 32'(RespThread), 32'((i - 1) % N));
    end

    // Load of index 5 after startup
    step(4'b0001, '0, idx_at(0, 5), '0, 1'b1);
    step('0, '0, '0, '0, 1'b1);
    check("idx5_data", RespData, EXP_IDX5);

    // Same-cycle store/load to one index returns the new store data
    step(4'b0001, 4'b0001, idx_at(0, 9), dat_at(0, 32'hCAFE_F00D), 1'b1);
    step(4'b0110, 4'b0010, idx_at(1, 9) | idx_at(2, 9), dat_at(1, 32'hDEAD_BEEF), 1'b1);
    step('0, '0, '0, '0, 1'b1);
    check("fwd_valid", 32'(RespValid), 32'h1);
    check("fwd_thread", 32'(RespThread), 32'h2);
    check("fwd_data", RespData, 32'hDEAD_BEEF);

    // Backpressure: held response, loads blocked, stores still granted
    step(4'b1000, 4'b1000, idx_at(3, 20), dat_at(3, 32'h0000_1234), 1'b1);
    step(4'b0001, '0, idx_at(0, 20), '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b1010, 4'b1000, idx_at(1, 21) | idx_at(3, 22), dat_at(3, 32'h7700 + 32'(i)), 1'b0);
      check("bp_grant", 32'(ReqGrant), 32'h8);
      check("bp_valid", 32'(RespValid), 32'h1);
      check("bp_data", RespData, 32'h0000_1234);
    end
    step(4'b0010, '0, idx_at(1, 22), '0, 1'b1);
    check("bp_release_grant", 32'(ReqGrant), 32'h2);

    // Reset while a response is stalled
    step(4'b0100, '0, idx_at(2, 3), '0, 1'b1);
    step('0, '0, '0, '0, 1'b0);
    check("pre_rst_stall", 32'(RespValid), 32'h1);
    apply_reset();
    repeat (INIT_CYCLES) step('1, '0, '0, '0, 1'b1);
    step('1, '0, idx_at(0, 7) | idx_at(1, 8) | idx_at(2, 9) | idx_at(3, 10), '0, 1'b1);
    check("post_rst_first", 32'(ReqGrant), 32'h1);

    // Random traffic over a small index range to provoke forwarding hits
    for (int n = 0; n < 400; n++) begin
      logic [N*7-1:0] ri;
      logic [N*32-1:0] rd;
      for (int t = 0; t < N; t++) begin
        ri[t*7 +: 7]   = 7'($urandom_range(0, 7));
        rd[t*32 +: 32] = $urandom;
      end
      step(N'($urandom), N'($urandom), ri, rd, $urandom_range(0, 3) != 0);
    end
    step('0, '0, '0, '0, 1'b1);
    step('0, '0, '0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
